// File: rtl/imm_gen_pkg.sv
// Shared opcode constants and format codes for the immediate generator.
package imm_gen_pkg;

   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] STORE     = 7'b0100011;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] JAL       = 7'b1101111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP        = 7'b0110011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_32     = 7'b0111011;
   localparam logic [6:0] LUI       = 7'b0110111;
   localparam logic [6:0] AUIPC     = 7'b0010111;
   localparam logic [6:0] SYSTEM    = 7'b1110011;
   localparam logic [6:0] FENCE     = 7'b0001111;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6,
      FMT_NONE = 3'd7
   } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Fetch-side and decode-side handshake bundle of the immediate generator.
interface imm_gen_pipe_if
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   fmt_e             out_fmt;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   // Driver of instructions and consumer of decoded entries.
   modport master (
      output in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
   );

   // The immediate generator stage itself.
   modport slave (
      input  in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
   );
endinterface

// File: rtl/imm_decode_comb.sv
// Purely combinational RISC-V immediate extraction and format classification.
module imm_decode_comb
   import imm_gen_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter bit ZIMM_EN = 1'b1
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm,
   output fmt_e            o_fmt,
   output logic            o_illegal
);

   logic [31:0] w_imm32;
   logic        w_zext;

   // Every immediate fits in 32 bits; build it there, then widen to XLEN.
   always_comb begin
      w_imm32   = 32'd0;
      w_zext    = 1'b0;
      o_fmt     = FMT_NONE;
      o_illegal = 1'b1;
      case (i_instr[6:0])
         OP_IMM, LOAD, JALR, FENCE: begin
            o_fmt     = FMT_I;
            o_illegal = 1'b0;
            w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
         end
         OP_IMM_32: begin
            if (XLEN == 64) begin
               o_fmt     = FMT_I;
               o_illegal = 1'b0;
               w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
            end
         end
         SYSTEM: begin
            o_illegal = 1'b0;
            if (ZIMM_EN && i_instr[14]) begin
               o_fmt   = FMT_Z;
               w_zext  = 1'b1;
               w_imm32 = {27'd0, i_instr[19:15]};
            end else begin
               o_fmt   = FMT_I;
               w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
         end
         STORE: begin
            o_fmt     = FMT_S;
            o_illegal = 1'b0;
            w_imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         end
         BRANCH: begin
            o_fmt     = FMT_B;
            o_illegal = 1'b0;
            w_imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
         end
         LUI, AUIPC: begin
            o_fmt     = FMT_U;
            o_illegal = 1'b0;
            w_imm32   = {i_instr[31:12], 12'd0};
         end
         JAL: begin
            o_fmt     = FMT_J;
            o_illegal = 1'b0;
            w_imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
         end
         OP: begin
            o_fmt     = FMT_R;
            o_illegal = 1'b0;
         end
         OP_32: begin
            if (XLEN == 64) begin
               o_fmt     = FMT_R;
               o_illegal = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Bit 31 of the 32-bit form carries the sign for every sign-extended format.
   assign o_imm = w_zext ? XLEN'(w_imm32) : XLEN'($signed(w_imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generator stage: decode at acceptance, 2-entry skid
// buffer with flush, and a saturating counter of delivered illegal entries.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int TAG_W   = 32,
   parameter bit ZIMM_EN = 1'b1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   imm_gen_pipe_if.slave    bus,
   output logic [CNT_W-1:0] illegal_cnt
);

   logic [XLEN-1:0]  w_dec_imm;
   fmt_e             w_dec_fmt;
   logic             w_dec_ill;
   logic             w_push;
   logic             w_pop;

   logic             r_head_valid;
   logic [XLEN-1:0]  r_head_imm;
   fmt_e             r_head_fmt;
   logic             r_head_ill;
   logic [TAG_W-1:0] r_head_tag;
   logic             r_skid_valid;
   logic [XLEN-1:0]  r_skid_imm;
   fmt_e             r_skid_fmt;
   logic             r_skid_ill;
   logic [TAG_W-1:0] r_skid_tag;
   logic [CNT_W-1:0] r_cnt;

   imm_decode_comb #(
      .XLEN    (XLEN),
      .ZIMM_EN (ZIMM_EN)
   ) u_dec (
      .i_instr   (bus.in_instr),
      .o_imm     (w_dec_imm),
      .o_fmt     (w_dec_fmt),
      .o_illegal (w_dec_ill)
   );

   // Ready depends only on the skid register, never on out_ready.
   assign bus.in_ready = !r_skid_valid;
   assign w_push       = bus.in_valid && !r_skid_valid;
   assign w_pop        = r_head_valid && bus.out_ready;

   // Head/skid update; flush overrides any push or pop in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head_valid <= 1'b0;
         r_head_imm   <= '0;
         r_head_fmt   <= FMT_R;
         r_head_ill   <= 1'b0;
         r_head_tag   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_imm   <= '0;
         r_skid_fmt   <= FMT_R;
         r_skid_ill   <= 1'b0;
         r_skid_tag   <= '0;
      end else if (flush) begin
         r_head_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else begin
         case ({w_push, w_pop})
            2'b01: begin
               if (r_skid_valid) begin
                  r_head_imm   <= r_skid_imm;
                  r_head_fmt   <= r_skid_fmt;
                  r_head_ill   <= r_skid_ill;
                  r_head_tag   <= r_skid_tag;
                  r_skid_valid <= 1'b0;
               end else begin
                  r_head_valid <= 1'b0;
               end
            end
            2'b10: begin
               if (!r_head_valid) begin
                  r_head_valid <= 1'b1;
                  r_head_imm   <= w_dec_imm;
                  r_head_fmt   <= w_dec_fmt;
                  r_head_ill   <= w_dec_ill;
                  r_head_tag   <= bus.in_tag;
               end else begin
                  r_skid_valid <= 1'b1;
                  r_skid_imm   <= w_dec_imm;
                  r_skid_fmt   <= w_dec_fmt;
                  r_skid_ill   <= w_dec_ill;
                  r_skid_tag   <= bus.in_tag;
               end
            end
            2'b11: begin
               // Push implies the skid is empty, so the new entry replaces the head.
               r_head_imm <= w_dec_imm;
               r_head_fmt <= w_dec_fmt;
               r_head_ill <= w_dec_ill;
               r_head_tag <= bus.in_tag;
            end
            default: ;
         endcase
      end
   end

   // Count illegal entries actually handed to the consumer, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_pop && r_head_ill && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign bus.out_valid   = r_head_valid;
   assign bus.out_imm     = r_head_imm;
   assign bus.out_fmt     = r_head_fmt;
   assign bus.out_illegal = r_head_ill;
   assign bus.out_tag     = r_head_tag;
   assign illegal_cnt     = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 instance (16-bit counter) and
// one XLEN=64 instance (2-bit counter) driven with identical stimulus.
module tb_imm_gen_pipe;
   import imm_gen_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] imm64;
      logic [2:0]  fmt64;
      logic        ill64;
      logic [31:0] imm32;
      logic [2:0]  fmt32;
      logic        ill32;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [15:0] cnt32;
   logic [1:0]  cnt64;

   int          n_cmp;
   int          n_bad;
   int          m_cnt32;
   int          m_cnt64;
   string       ctx;
   vec_t        vecs [18];

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

   imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ZIMM_EN(1'b1), .CNT_W(16)) dut32 (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .bus         (bus32),
      .illegal_cnt (cnt32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ZIMM_EN(1'b1), .CNT_W(2)) dut64 (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .bus         (bus64),
      .illegal_cnt (cnt64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s [%s]: got %h expected %h", name, ctx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] tag,
                        input logic ordy);
      bus32.in_valid  = v;
      bus32.in_instr  = instr;
      bus32.in_tag    = tag;
      bus32.out_ready = ordy;
      bus64.in_valid  = v;
      bus64.in_instr  = instr;
      bus64.in_tag    = tag;
      bus64.out_ready = ordy;
   endtask

   task automatic chk_valid_tag(input string nm, input logic ev, input logic [31:0] etag);
      chk({nm, "_valid32"}, bus32.out_valid, ev);
      chk({nm, "_valid64"}, bus64.out_valid, ev);
      if (ev) begin
         chk({nm, "_tag32"}, bus32.out_tag, etag);
         chk({nm, "_tag64"}, bus64.out_tag, etag);
      end
   endtask

   // One instruction through an empty stage: accept, check, then pop.
   task automatic apply_vec(input vec_t v, input logic [31:0] tag);
      $sformat(ctx, "instr=%h", v.instr);
      drive(1'b1, v.instr, tag, 1'b1);
      chk("in_ready32", bus32.in_ready, 1'b1);
      chk("in_ready64", bus64.in_ready, 1'b1);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      chk_valid_tag("out", 1'b1, tag);
      chk("imm32", bus32.out_imm, v.imm32);
      chk("imm64", bus64.out_imm, v.imm64);
      chk("fmt32", bus32.out_fmt, v.fmt32);
      chk("fmt64", bus64.out_fmt, v.fmt64);
      chk("ill32", bus32.out_illegal, v.ill32);
      chk("ill64", bus64.out_illegal, v.ill64);
      if (v.ill32) m_cnt32++;
      if (v.ill64 && m_cnt64 != 3) m_cnt64++;
      tick();
      chk("drained_valid32", bus32.out_valid, 1'b0);
      chk("drained_valid64", bus64.out_valid, 1'b0);
      chk("cnt32", cnt32, m_cnt32);
      chk("cnt64", cnt64, m_cnt64);
      $display("vec instr=%h tag=%h imm32=%h imm64=%h fmt=%0d/%0d ill=%0d/%0d",
               v.instr, tag, v.imm32, v.imm64, v.fmt32, v.fmt64, v.ill32, v.ill64);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t z;
      n_cmp = 0;
      n_bad = 0;
      m_cnt32 = 0;
      m_cnt64 = 0;
      ctx = "reset";

      vecs[0]  = '{32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 3'd1, 1'b0};
      vecs[1]  = '{32'h80000037, 64'hFFFFFFFF_80000000, 3'd4, 1'b0, 32'h80000000, 3'd4, 1'b0};
      vecs[2]  = '{32'h12345037, 64'h00000000_12345000, 3'd4, 1'b0, 32'h12345000, 3'd4, 1'b0};
      vecs[3]  = '{32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC, 3'd3, 1'b0};
      vecs[4]  = '{32'h3057D073, 64'h00000000_0000000F, 3'd6, 1'b0, 32'h0000000F, 3'd6, 1'b0};
      vecs[5]  = '{32'hFE112E23, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0, 32'hFFFFFFFC, 3'd2, 1'b0};
      vecs[6]  = '{32'h001000EF, 64'h00000000_00000800, 3'd5, 1'b0, 32'h00000800, 3'd5, 1'b0};
      vecs[7]  = '{32'hFFDFF0EF, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0, 32'hFFFFFFFC, 3'd5, 1'b0};
      vecs[8]  = '{32'h002081B3, 64'h00000000_00000000, 3'd0, 1'b0, 32'h00000000, 3'd0, 1'b0};
      vecs[9]  = '{32'h002081BB, 64'h00000000_00000000, 3'd0, 1'b0, 32'h00000000, 3'd7, 1'b1};
      vecs[10] = '{32'hFFF0809B, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0, 32'h00000000, 3'd7, 1'b1};
      vecs[11] = '{32'h0FF0000F, 64'h00000000_000000FF, 3'd1, 1'b0, 32'h000000FF, 3'd1, 1'b0};
      vecs[12] = '{32'h80012083, 64'hFFFFFFFF_FFFFF800, 3'd1, 1'b0, 32'hFFFFF800, 3'd1, 1'b0};
      vecs[13] = '{32'h7FF080E7, 64'h00000000_000007FF, 3'd1, 1'b0, 32'h000007FF, 3'd1, 1'b0};
      vecs[14] = '{32'hFFFFF097, 64'hFFFFFFFF_FFFFF000, 3'd4, 1'b0, 32'hFFFFF000, 3'd4, 1'b0};
      vecs[15] = '{32'h34011073, 64'h00000000_00000340, 3'd1, 1'b0, 32'h00000340, 3'd1, 1'b0};
      vecs[16] = '{32'h00000010, 64'h00000000_00000000, 3'd7, 1'b1, 32'h00000000, 3'd7, 1'b1};
      vecs[17] = '{32'hFFFFFFFF, 64'h00000000_00000000, 3'd7, 1'b1, 32'h00000000, 3'd7, 1'b1};
      z        = '{32'h00000000, 64'h00000000_00000000, 3'd7, 1'b1, 32'h00000000, 3'd7, 1'b1};

      // Reset state while rst is held.
      rst = 1'b1;
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      #2;
      chk_valid_tag("rst", 1'b0, 32'd0);
      chk("rst_imm64", bus64.out_imm, 64'd0);
      chk("rst_tag32", bus32.out_tag, 32'd0);
      chk("rst_cnt32", cnt32, 16'd0);
      chk("rst_cnt64", cnt64, 2'd0);
      #10 rst = 1'b0;
      tick();
      chk("post_rst_in_ready32", bus32.in_ready, 1'b1);
      chk("post_rst_in_ready64", bus64.in_ready, 1'b1);
      $display("reset checked");

      // Decode table, one instruction at a time through an empty stage.
      for (int i = 0; i < 18; i++) apply_vec(vecs[i], 32'h1000 + 32'(i * 4));

      // Backpressure: three offered, two accepted, then drained in order.
      ctx = "skid";
      drive(1'b1, 32'h00100093, 32'hA0, 1'b0);
      chk("skid_rdy0", bus32.in_ready & bus64.in_ready, 1'b1);
      tick();
      chk_valid_tag("skid_c1", 1'b1, 32'hA0);
      drive(1'b1, 32'h00200093, 32'hB0, 1'b0);
      chk("skid_rdy1", bus32.in_ready & bus64.in_ready, 1'b1);
      tick();
      drive(1'b1, 32'h00300093, 32'hC0, 1'b0);
      chk("skid_full_rdy32", bus32.in_ready, 1'b0);
      chk("skid_full_rdy64", bus64.in_ready, 1'b0);
      chk_valid_tag("skid_c2", 1'b1, 32'hA0);
      chk("skid_c2_imm", bus32.out_imm, 32'd1);
      drive(1'b1, 32'h00300093, 32'hC0, 1'b1);
      tick();
      chk_valid_tag("skid_c3", 1'b1, 32'hB0);
      chk("skid_c3_imm", bus64.out_imm, 64'd2);
      chk("skid_c3_rdy", bus32.in_ready & bus64.in_ready, 1'b1);
      tick();
      chk_valid_tag("skid_c4", 1'b1, 32'hC0);
      chk("skid_c4_imm", bus32.out_imm, 32'd3);
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      tick();
      chk_valid_tag("skid_c5", 1'b0, 32'd0);
      $display("skid sequence A,B,C checked");

      // Asynchronous reset with an illegal entry held in the head.
      ctx = "async_rst";
      drive(1'b1, 32'h00000000, 32'hD0, 1'b0);
      tick();
      drive(1'b0, 32'd0, 32'd0, 1'b0);
      chk_valid_tag("arst_pre", 1'b1, 32'hD0);
      #2 rst = 1'b1;
      #1;
      chk_valid_tag("arst", 1'b0, 32'd0);
      chk("arst_cnt32", cnt32, 16'd0);
      chk("arst_cnt64", cnt64, 2'd0);
      m_cnt32 = 0;
      m_cnt64 = 0;
      #1 rst = 1'b0;
      tick();
      $display("async reset mid-stream checked");

      // Illegal counter: three deliveries, then saturation of the 2-bit counter.
      for (int k = 0; k < 4; k++) apply_vec(z, 32'hE0 + 32'(k));
      ctx = "sat";
      chk("sat_cnt32", cnt32, 16'd4);
      chk("sat_cnt64", cnt64, 2'd3);
      $display("illegal counter checked cnt32=%0d cnt64=%0d", cnt32, cnt64);

      // Flush with both entries full; the head pops in the flush cycle.
      ctx = "flush_full";
      drive(1'b1, 32'h00000000, 32'hF0, 1'b0);
      tick();
      drive(1'b1, 32'h00500093, 32'hF1, 1'b0);
      tick();
      chk("fl_full_rdy", bus32.in_ready | bus64.in_ready, 1'b0);
      flush = 1'b1;
      drive(1'b1, 32'h00700093, 32'hF2, 1'b1);
      m_cnt32++;
      tick();
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      chk_valid_tag("fl_full", 1'b0, 32'd0);
      chk("fl_full_rdy32", bus32.in_ready, 1'b1);
      chk("fl_full_rdy64", bus64.in_ready, 1'b1);
      chk("fl_cnt32", cnt32, m_cnt32);
      chk("fl_cnt64", cnt64, m_cnt64);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_valid_tag("fl_full_after", 1'b0, 32'd0);
      end
      $display("flush with full buffer checked");

      // Flush with only the head valid: the input offered alongside is dropped.
      ctx = "flush_head";
      drive(1'b1, 32'h00900093, 32'hF4, 1'b0);
      tick();
      flush = 1'b1;
      drive(1'b1, 32'h00A00093, 32'hF5, 1'b0);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b1);
      chk_valid_tag("fl_head", 1'b0, 32'd0);
      tick();
      chk_valid_tag("fl_head_after", 1'b0, 32'd0);
      $display("flush with offered input checked");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Next-generation immediate generator. It is a registered decode-side stage that extracts and sign-extends RISC-V immediates for XLEN of 32 or 64, and classifies the instruction format. It also flags illegal encodings, carries a tag (the PC) alongside the instruction, and decouples the fetch and decode sides with a valid/ready handshake and a 2-entry skid buffer. It sits between the IF/ID pipeline register and the decode/execute path, and supports flush on branch redirect.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64 only.
TAG_W, 32, width of the passthrough tag (normally the PC).
ZIMM_EN, 1, when 1, SYSTEM opcode with funct3[2]=1 produces a zero-extended 5-bit CSR immediate.
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  input  1  clock; everything is sampled on the rising edge.
rst  input  1  asynchronous, active-high reset.
flush  input  1  synchronous kill of all buffered entries.
in_valid  input  1  instruction and tag are valid.
in_ready  output  1  stage can accept this cycle.
in_instr  input  32  instruction word.
in_tag  input  TAG_W  tag or PC passed through unchanged.
out_valid  output  1  output entry is valid.
out_ready  input  1  consumer accepts this cycle.
out_imm  output  XLEN  extended immediate.
out_fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, Z=6, NONE=7.
out_illegal  output  1  unrecognised opcode, or instr[1:0] != 2'b11.
out_tag  output  TAG_W  tag of the output entry.
illegal_cnt  output  CNT_W  saturating count of illegal instructions delivered.

Behaviour:
- Reset, asynchronous:
  - out_valid=0, both buffer entries invalid, illegal_cnt=0.
  - in_ready=1 from the first cycle after rst deasserts.
  - Data outputs are 0.
  - Reset asserted mid-transfer discards all entries without any output handshake.
- Transfers: input transfer when in_valid&in_ready; output transfer when out_valid&out_ready.
- Latency: exactly 1 cycle from input acceptance to out_valid, when the buffer is empty.
- Combinational decode of in_instr[6:0], captured at acceptance:
  - OP-IMM, LOAD, JALR, and SYSTEM with funct3[2]=0: fmt I, imm = sext(instr[31:20]).
  - STORE: fmt S, imm = sext({instr[31:25], instr[11:7]}).
  - BRANCH: fmt B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - LUI, AUIPC: fmt U, imm = sext({instr[31:12], 12'b0}). Bit 31 extends to XLEN, so upper bits are set when XLEN=64 and instr[31]=1.
  - JAL: fmt J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - SYSTEM with funct3[2]=1 and ZIMM_EN=1: fmt Z, imm = zext(instr[19:15]). With ZIMM_EN=0 it is treated as fmt I.
  - OP, and OP-32 when XLEN=64: fmt R, imm=0.
  - FENCE, and OP-IMM-32 when XLEN=64: fmt I, using the I rule.
  - Anything else: fmt NONE, imm=0, illegal=1.
- Skid buffer:
  - Two entries, a head (which drives the outputs) and a skid.
  - in_ready = !skid_valid, registered; it is not combinationally dependent on out_ready.
  - Ordering is strict FIFO.
  - Simultaneous input and output transfer with only the head valid: the head is replaced, there is no bubble, and throughput is 1 per cycle.
  - Full (both entries valid): in_ready=0. A pop moves the skid into the head, and in_ready rises the next cycle.
  - Empty: out_valid=0, and out_ready is ignored.
- flush:
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - An input offered in the same cycle as flush is dropped.
  - An output transfer in the flush cycle completes normally.
  - flush has priority over all buffer updates.
- illegal_cnt:
  - Increments by 1 on each output transfer with out_illegal=1.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- out_tag travels with its entry unchanged.

Decomposition:
- Shared package imm_gen_pkg: opcode localparams (LOAD, STORE, BRANCH, JALR, JAL, OP_IMM, OP, OP_IMM_32, OP_32, LUI, AUIPC, SYSTEM, FENCE) and the fmt codes.
- One sub-module, imm_decode_comb: purely combinational decode, from instr to {imm, fmt, illegal}, parametrised by XLEN and ZIMM_EN.
- Top level: skid buffer, flush handling and counter.

Test Plan:
- XLEN=32, in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, illegal=0, tag unchanged.
- XLEN=64: 0x80000037 -> imm=0xFFFFFFFF80000000, fmt=4. Also 0x12345037 -> imm=0x0000000012345000.
- 0xFE000EE3 (beq x0,x0,-4) -> imm=-4, fmt=3. Also 0x3057D073 (csrrwi, zimm=15) -> imm=15, fmt=6.
- out_ready=0 while offering 3 back-to-back instructions -> two accepted, then in_ready=0. Releasing out_ready -> outputs in order, 1 per cycle, none lost or duplicated.
- Both entries full, pulse flush -> next cycle out_valid=0, in_ready=1. The instruction offered during the flush cycle is never output.
- 0x00000000 delivered 3 times -> illegal=1, fmt=7, imm=0, illegal_cnt=3. With CNT_W=2 it stops at 3. rst asserted mid-stream -> count 0 and out_valid 0 immediately, independent of clk.
